// File: rtl/uc_secuenciador.sv
// Control unit for the single-cycle stack datapath: opcode decode, I/O stall
// with req/ack handshake and timeout, return-stack tracking and HALT.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | decode one instruction per cycle
// IO_WAIT | PC stalled, bus request held until io_ack or timeout
// HALT    | everything frozen, only reset leaves
module uc_secuenciador #(
    parameter int STACK_DEPTH = 8,
    parameter int TIMEOUT     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       io_ack,
    output logic       s_inc,
    output logic       s_pila,
    output logic       s_inm,
    output logic       s_datos,
    output logic       we3,
    output logic       wez,
    output logic       push,
    output logic       pop,
    output logic       oe,
    output logic [2:0] op_alu,
    output logic       pc_en,
    output logic       io_req,
    output logic       io_we,
    output logic       halted,
    output logic       stack_err,
    output logic       bus_err
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int SW = $clog2(STACK_DEPTH + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] STACK_FULL = SW'(STACK_DEPTH);

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        IO_WAIT = 3'd1,
        HALT    = 3'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [SW-1:0] sp_cnt, sp_nxt;
    logic          io_out, io_out_nxt;
    logic          serr_q, serr_nxt;
    logic          berr_q, berr_nxt;

    logic       s_inc_c, s_pila_c, s_inm_c, s_datos_c;
    logic       we3_c, wez_c, push_c, pop_c, oe_c;
    logic       pc_en_c, io_req_c, io_we_c, halted_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            cnt    <= '0;
            sp_cnt <= '0;
            io_out <= 1'b0;
            serr_q <= 1'b0;
            berr_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sp_cnt <= sp_nxt;
            io_out <= io_out_nxt;
            serr_q <= serr_nxt;
            berr_q <= berr_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        sp_nxt     = sp_cnt;
        io_out_nxt = io_out;
        serr_nxt   = serr_q;
        berr_nxt   = berr_q;
        s_inc_c    = 1'b1;
        s_pila_c   = 1'b1;
        s_inm_c    = 1'b1;
        s_datos_c  = 1'b0;
        we3_c      = 1'b0;
        wez_c      = 1'b0;
        push_c     = 1'b0;
        pop_c      = 1'b0;
        oe_c       = 1'b0;
        pc_en_c    = 1'b1;
        io_req_c   = 1'b0;
        io_we_c    = 1'b0;
        halted_c   = 1'b0;

        unique case (state)
            RUN: begin
                casez (opcode)
                    6'b001???: begin
                        we3_c = 1'b1;
                        wez_c = 1'b1;
                    end
                    6'b010???: begin
                        s_inm_c = 1'b0;
                        we3_c   = 1'b1;
                        wez_c   = 1'b1;
                    end
                    6'b100000: s_inc_c = 1'b0;
                    6'b100001: s_inc_c = ~z;
                    6'b100010: s_inc_c = z;
                    6'b100011: begin
                        // A CALL on a full stack degrades to a NOP
                        if (sp_cnt == STACK_FULL) begin
                            serr_nxt = 1'b1;
                        end else begin
                            s_inc_c = 1'b0;
                            push_c  = 1'b1;
                            sp_nxt  = sp_cnt + SW'(1);
                        end
                    end
                    6'b100100: begin
                        if (sp_cnt == '0) begin
                            serr_nxt = 1'b1;
                        end else begin
                            s_pila_c = 1'b0;
                            pop_c    = 1'b1;
                            sp_nxt   = sp_cnt - SW'(1);
                        end
                    end
                    6'b110000, 6'b110001: begin
                        pc_en_c    = 1'b0;
                        state_nxt  = IO_WAIT;
                        cnt_nxt    = '0;
                        io_out_nxt = opcode[0];
                    end
                    6'b111111: begin
                        pc_en_c   = 1'b0;
                        state_nxt = HALT;
                    end
                    default: ;
                endcase
            end
            IO_WAIT: begin
                io_req_c = 1'b1;
                io_we_c  = io_out;
                oe_c     = io_out;
                pc_en_c  = 1'b0;
                // ack is checked first so it wins over a simultaneous timeout
                if (io_ack) begin
                    we3_c     = ~io_out;
                    s_datos_c = ~io_out;
                    pc_en_c   = 1'b1;
                    state_nxt = RUN;
                end else if (cnt == CNT_LAST) begin
                    berr_nxt  = 1'b1;
                    pc_en_c   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            HALT: begin
                pc_en_c  = 1'b0;
                halted_c = 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    // Everything is forced low while reset is held
    assign s_inc     = ~reset & s_inc_c;
    assign s_pila    = ~reset & s_pila_c;
    assign s_inm     = ~reset & s_inm_c;
    assign s_datos   = ~reset & s_datos_c;
    assign we3       = ~reset & we3_c;
    assign wez       = ~reset & wez_c;
    assign push      = ~reset & push_c;
    assign pop       = ~reset & pop_c;
    assign oe        = ~reset & oe_c;
    assign op_alu    = reset ? 3'b000 : opcode[2:0];
    assign pc_en     = ~reset & pc_en_c;
    assign io_req    = ~reset & io_req_c;
    assign io_we     = ~reset & io_we_c;
    assign halted    = ~reset & halted_c;
    assign stack_err = ~reset & serr_q;
    assign bus_err   = ~reset & berr_q;

endmodule

// File: tb/tb_uc_secuenciador.sv
// Self-checking bench for uc_secuenciador: directed scenarios plus random
// opcode/flag/ack traffic compared cycle by cycle against a behavioural model.
module tb_uc_secuenciador;

    localparam int STACK_DEPTH = 8;
    localparam int TIMEOUT     = 16;
    localparam int M_RUN = 0, M_IO = 1, M_HALT = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       z = 1'b0;
    logic       io_ack = 1'b0;
    logic       s_inc, s_pila, s_inm, s_datos, we3, wez, push, pop, oe;
    logic [2:0] op_alu;
    logic       pc_en, io_req, io_we, halted, stack_err, bus_err;

    typedef struct packed {
        logic       s_inc, s_pila, s_inm, s_datos, we3, wez, push, pop, oe;
        logic [2:0] op_alu;
        logic       pc_en, io_req, io_we, halted, stack_err, bus_err;
    } outs_t;

    uc_secuenciador #(.STACK_DEPTH(STACK_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .io_ack(io_ack),
        .s_inc(s_inc), .s_pila(s_pila), .s_inm(s_inm), .s_datos(s_datos),
        .we3(we3), .wez(wez), .push(push), .pop(pop), .oe(oe),
        .op_alu(op_alu), .pc_en(pc_en), .io_req(io_req), .io_we(io_we),
        .halted(halted), .stack_err(stack_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Behavioural model: mode, stack depth, cycles spent waiting, sticky flags
    int m_mode, m_depth, m_wait;
    bit m_out, m_serr, m_berr;
    int n_mode, n_depth, n_wait;
    bit n_out, n_serr, n_berr;
    outs_t last;

    task automatic model_reset();
        m_mode = M_RUN; m_depth = 0; m_wait = 0;
        m_out = 0; m_serr = 0; m_berr = 0;
    endtask

    task automatic model_eval(input logic [5:0] op, input logic zz, input logic ack,
                              output outs_t e);
        int grp;
        int code;
        grp  = int'(op) / 8;
        code = int'(op);
        e = '0;
        n_mode = m_mode; n_depth = m_depth; n_wait = m_wait;
        n_out = m_out; n_serr = m_serr; n_berr = m_berr;
        e.s_inc = 1; e.s_pila = 1; e.s_inm = 1;
        e.op_alu = 3'(code % 8);
        e.stack_err = m_serr;
        e.bus_err = m_berr;
        if (m_mode == M_RUN) begin
            e.pc_en = 1;
            if (grp == 1) begin
                e.we3 = 1; e.wez = 1;
            end else if (grp == 2) begin
                e.s_inm = 0; e.we3 = 1; e.wez = 1;
            end else if (code == 32) begin
                e.s_inc = 0;
            end else if (code == 33) begin
                e.s_inc = !zz;
            end else if (code == 34) begin
                e.s_inc = zz;
            end else if (code == 35) begin
                if (m_depth < STACK_DEPTH) begin
                    e.push = 1; e.s_inc = 0; n_depth = m_depth + 1;
                end else n_serr = 1;
            end else if (code == 36) begin
                if (m_depth > 0) begin
                    e.pop = 1; e.s_pila = 0; n_depth = m_depth - 1;
                end else n_serr = 1;
            end else if (code == 48 || code == 49) begin
                e.pc_en = 0; n_mode = M_IO; n_wait = 0; n_out = (code == 49);
            end else if (code == 63) begin
                e.pc_en = 0; n_mode = M_HALT;
            end
        end else if (m_mode == M_IO) begin
            e.io_req = 1; e.io_we = m_out; e.oe = m_out;
            if (ack) begin
                e.pc_en = 1; n_mode = M_RUN;
                if (!m_out) begin
                    e.we3 = 1; e.s_datos = 1;
                end
            end else if (m_wait + 1 == TIMEOUT) begin
                e.pc_en = 1; n_berr = 1; n_mode = M_RUN;
            end else begin
                n_wait = m_wait + 1;
            end
        end else begin
            e.halted = 1;
        end
    endtask

    function automatic outs_t sample();
        outs_t s;
        s = {s_inc, s_pila, s_inm, s_datos, we3, wez, push, pop, oe,
             op_alu, pc_en, io_req, io_we, halted, stack_err, bus_err};
        return s;
    endfunction

    task automatic step(input logic [5:0] op, input logic zz, input logic ack);
        outs_t e;
        @(negedge clk);
        opcode = op; z = zz; io_ack = ack;
        #1;
        last = sample();
        model_eval(op, zz, ack, e);
        chk("cycle", 32'(last), 32'(e));
        @(posedge clk);
        m_mode = n_mode; m_depth = n_depth; m_wait = n_wait;
        m_out = n_out; m_serr = n_serr; m_berr = n_berr;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        opcode = 6'($urandom);
        #1;
        chk("reset_outs", 32'(sample()), 32'(0));
        model_reset();
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    function automatic logic [5:0] pick_op();
        int r;
        r = $urandom_range(0, 99);
        if (r < 10) return 6'd0;
        if (r < 25) return {3'b001, 3'($urandom)};
        if (r < 35) return {3'b010, 3'($urandom)};
        if (r < 42) return 6'd32;
        if (r < 48) return 6'd33;
        if (r < 54) return 6'd34;
        if (r < 66) return 6'd35;
        if (r < 78) return 6'd36;
        if (r < 84) return 6'd48;
        if (r < 90) return 6'd49;
        if (r < 92) return 6'd63;
        return 6'($urandom);
    endfunction

    initial begin
        model_reset();
        do_reset();

        step(6'b001010, 0, 0);
        chk("alu_we3", 32'(last.we3), 1);
        chk("alu_wez", 32'(last.wez), 1);
        chk("alu_op", 32'(last.op_alu), 2);
        chk("alu_pc_en", 32'(last.pc_en), 1);
        chk("alu_s_inm", 32'(last.s_inm), 1);
        chk("alu_flags", 32'({last.halted, last.stack_err, last.bus_err}), 0);

        step(6'b010011, 0, 0);
        chk("imm_s_inm", 32'(last.s_inm), 0);
        step(6'd33, 1, 0);
        chk("jz_z1", 32'(last.s_inc), 0);
        step(6'd33, 0, 0);
        chk("jz_z0", 32'(last.s_inc), 1);
        step(6'd34, 1, 0);
        chk("jnz_z1", 32'(last.s_inc), 1);

        for (int i = 0; i < STACK_DEPTH; i++) begin
            step(6'd35, 0, 0);
            chk("call_push", 32'(last.push), 1);
        end
        step(6'd35, 0, 0);
        chk("call_full_push", 32'(last.push), 0);
        chk("call_full_s_inc", 32'(last.s_inc), 1);
        step(6'd0, 0, 0);
        chk("call_full_err", 32'(last.stack_err), 1);
        for (int i = 0; i < STACK_DEPTH; i++) begin
            step(6'd36, 0, 0);
            chk("ret_pop", 32'({last.pop, last.s_pila}), 32'(2'b10));
        end
        step(6'd36, 0, 0);
        chk("ret_empty_pop", 32'(last.pop), 0);
        chk("ret_empty_s_pila", 32'(last.s_pila), 1);

        do_reset();
        step(6'd48, 0, 0);
        chk("in_run_pc_en", 32'(last.pc_en), 0);
        chk("in_run_io_req", 32'(last.io_req), 0);
        for (int i = 1; i <= 3; i++) begin
            step(6'd48, 0, (i == 3));
            chk("in_io_req", 32'(last.io_req), 1);
            chk("in_pc_en", 32'(last.pc_en), 32'(i == 3));
            chk("in_we3", 32'({last.we3, last.s_datos}), (i == 3) ? 3 : 0);
        end
        step(6'd0, 0, 0);
        chk("in_io_req_drop", 32'(last.io_req), 0);

        step(6'd49, 0, 0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            step(6'd49, 0, 0);
            chk("out_oe_we", 32'({last.oe, last.io_we}), 3);
            chk("out_to_pc_en", 32'(last.pc_en), 32'(i == TIMEOUT));
            chk("out_to_we3", 32'(last.we3), 0);
        end
        step(6'd0, 0, 0);
        chk("out_to_bus_err", 32'(last.bus_err), 1);
        chk("out_to_io_req", 32'(last.io_req), 0);

        do_reset();
        step(6'd49, 0, 0);
        for (int i = 1; i <= TIMEOUT; i++) begin
            step(6'd49, 0, (i == TIMEOUT));
            chk("out_ack_pc_en", 32'(last.pc_en), 32'(i == TIMEOUT));
        end
        step(6'd0, 0, 0);
        chk("out_ack_no_bus_err", 32'(last.bus_err), 0);

        step(6'd49, 0, 0);
        step(6'd49, 0, 0);
        do_reset();
        step(6'd0, 0, 0);
        chk("io_reset_req", 32'(last.io_req), 0);

        step(6'd63, 0, 0);
        chk("halt_op_pc_en", 32'(last.pc_en), 0);
        for (int i = 0; i < 20; i++) begin
            step(6'($urandom), 1'($urandom), 1'($urandom));
            chk("halt_hold", 32'({last.halted, last.pc_en}), 32'(2'b10));
        end
        do_reset();
        step(6'd0, 0, 0);
        chk("halt_exit", 32'({last.halted, last.pc_en}), 32'(2'b01));

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0 || (m_mode == M_HALT && $urandom_range(0, 7) == 0))
                do_reset();
            else
                step(pick_op(), 1'($urandom), ($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
